// File: rtl/collector_pkg.sv
// Shared defaults and row types for the systolic-array result collector.
// Parameterised instances define their own lane/row types from these shapes.
package collector_pkg;

    localparam int DEFAULT_DIM   = 8;
    localparam int DEFAULT_BITS  = 64;
    localparam int DEFAULT_DEPTH = 8;

    typedef logic [DEFAULT_BITS-1:0] elem_t;
    typedef elem_t [DEFAULT_DIM-1:0] row_t;

endpackage

// File: rtl/lane_delay.sv
// Enabled shift chain of LEN stages used to deskew one array lane.
// LEN=0 degenerates to a combinational pass-through.
module lane_delay
    import collector_pkg::*;
#(
    parameter int LEN  = 1,
    parameter int BITS = DEFAULT_BITS
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clear,
    input  logic            en,
    input  logic [BITS-1:0] d,
    output logic [BITS-1:0] q
);

    generate
        if (LEN == 0) begin : g_wire
            logic w_unused;
            assign w_unused = ^{clk, rst_n, clear, en};
            assign q        = d;
        end else begin : g_chain
            logic [BITS-1:0] r_pipe [LEN];

            // NOTE: sequential state uses non-blocking assignments so every stage
            // samples its predecessor's pre-edge value and the chain shifts by one.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < LEN; i++) r_pipe[i] <= '0;
                end else if (clear) begin
                    for (int i = 0; i < LEN; i++) r_pipe[i] <= '0;
                end else if (en) begin
                    r_pipe[0] <= d;
                    for (int i = 1; i < LEN; i++) r_pipe[i] <= r_pipe[i-1];
                end
            end

            assign q = r_pipe[LEN-1];
        end
    endgenerate

endmodule

// File: rtl/result_collector.sv
// Deskews the DIM skewed result lanes of the systolic array into whole rows
// and queues them in a DEPTH-row circular buffer drained over valid/ready.
module result_collector
    import collector_pkg::*;
#(
    parameter int DIM   = DEFAULT_DIM,
    parameter int BITS  = DEFAULT_BITS,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clear,
    input  logic                         in_en,
    input  logic                         in_valid,
    input  logic [DIM*BITS-1:0]          in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DIM*BITS-1:0]          out_data,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    typedef logic [BITS-1:0] lane_t;
    typedef lane_t [DIM-1:0] line_t;

    line_t             w_in_row;
    line_t             w_aligned;
    logic              w_tag;
    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_write;
    logic              w_drop;

    line_t             r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_overflow;

    assign w_in_row = in_data;

    // Lane i arrives i enabled cycles after lane 0, so it waits DIM-1-i stages.
    generate
        for (genvar g = 0; g < DIM; g++) begin : g_lane
            lane_delay #(
                .LEN  (DIM-1-g),
                .BITS (BITS)
            ) u_lane (
                .clk   (clk),
                .rst_n (rst_n),
                .clear (clear),
                .en    (in_en),
                .d     (w_in_row[g]),
                .q     (w_aligned[g])
            );
        end
    endgenerate

    lane_delay #(
        .LEN  (DIM-1),
        .BITS (1)
    ) u_tag (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .en    (in_en),
        .d     (in_valid),
        .q     (w_tag)
    );

    assign w_push  = in_en & w_tag;
    assign w_pop   = out_valid & out_ready;
    assign w_full  = (r_count == CNT_W'(DEPTH));
    // A full buffer still accepts a row when a pop frees the slot on the same edge.
    assign w_write = w_push & (~w_full | w_pop);
    assign w_drop  = w_push & w_full & ~w_pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (clear) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_write) r_wptr <= r_wptr + PTR_W'(1);
            if (w_pop)   r_rptr <= r_rptr + PTR_W'(1);
            r_count <= r_count + CNT_W'(w_write) - CNT_W'(w_pop);
            if (w_drop)  r_overflow <= 1'b1;
        end
    end

    // NOTE: the row storage has no reset; occupancy is tracked by r_count and the
    // output is forced to zero when empty, so stale contents are never visible.
    always_ff @(posedge clk) begin
        if (w_write && !clear) r_mem[r_wptr] <= w_aligned;
    end

    assign out_valid = (r_count != '0);
    assign out_data  = out_valid ? r_mem[r_rptr] : '0;
    assign count     = r_count;
    assign full      = w_full;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_result_collector.sv
// Self-checking bench for result_collector: directed scenarios plus randomized
// traffic checked by a scoreboard against a row-level reference model.
module tb_result_collector;

    localparam int DIM   = 4;
    localparam int BITS  = 16;
    localparam int DEPTH = 4;
    localparam int W     = DIM*BITS;
    localparam int CNT_W = $clog2(DEPTH+1);

    logic             clk;
    logic             rst_n;
    logic             clear;
    logic             in_en;
    logic             in_valid;
    logic [W-1:0]     in_data;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_data;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             overflow;

    logic             clear1;
    logic             in_en1;
    logic             in_valid1;
    logic [BITS-1:0]  in_data1;
    logic             out_valid1;
    logic             out_ready1;
    logic [BITS-1:0]  out_data1;
    logic [1:0]       count1;
    logic             full1;
    logic             overflow1;

    result_collector #(.DIM(DIM), .BITS(BITS), .DEPTH(DEPTH)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_en     (in_en),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count),
        .full      (full),
        .overflow  (overflow)
    );

    result_collector #(.DIM(1), .BITS(BITS), .DEPTH(2)) u_dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear1),
        .in_en     (in_en1),
        .in_valid  (in_valid1),
        .in_data   (in_data1),
        .out_valid (out_valid1),
        .out_ready (out_ready1),
        .out_data  (out_data1),
        .count     (count1),
        .full      (full1),
        .overflow  (overflow1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: rows started at enabled-cycle index k, accepted rows, occupancy.
    logic [W-1:0] hist [int];
    logic [W-1:0] exp_q [$];
    int           m_cnt  = 0;
    bit           m_ovf  = 1'b0;
    int           en_idx = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic model_reset();
        m_cnt = 0;
        m_ovf = 1'b0;
        exp_q.delete();
        hist.delete();
    endtask

    // Effect of one clock edge, from the row-level rules.
    task automatic model_edge();
        bit push, pop, acc;
        int done;
        if (!rst_n || clear) begin
            model_reset();
        end else begin
            done = en_idx - (DIM-1);
            pop  = (m_cnt > 0) && out_ready;
            push = in_en && hist.exists(done);
            acc  = push && ((m_cnt < DEPTH) || pop);
            if (push && !acc) m_ovf = 1'b1;
            if (acc) exp_q.push_back(hist[done]);
            if (push) hist.delete(done);
            m_cnt = m_cnt + int'(acc) - int'(pop);
        end
        if (in_en) en_idx++;
    endtask

    // One cycle: drive skewed lanes for this enabled index, then take the edge.
    task automatic cyc(input bit en, input bit v, input logic [W-1:0] row,
                       input bit rdy, input bit clr);
        logic [W-1:0] d;
        d        = {$urandom, $urandom};
        in_valid = en ? v : 1'($urandom);
        if (en) begin
            if (v) hist[en_idx] = row;
            for (int i = 0; i < DIM; i++)
                if (hist.exists(en_idx - i))
                    d[i*BITS +: BITS] = hist[en_idx - i][i*BITS +: BITS];
        end
        in_en     = en;
        in_data   = d;
        out_ready = rdy;
        clear     = clr;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, '0, rdy, 1'b0);
    endtask

    function automatic logic [W-1:0] rep(input logic [BITS-1:0] e);
        return {DIM{e}};
    endfunction

    // Scoreboard monitor: status every cycle, row data against the expected queue.
    always @(negedge clk) begin
        if (rst_n) begin
            check("count",     W'(count),     W'(m_cnt));
            check("out_valid", W'(out_valid), W'(m_cnt > 0));
            check("full",      W'(full),      W'(m_cnt == DEPTH));
            check("overflow",  W'(overflow),  W'(m_ovf));
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL sb_row: got %h expected no row", out_data);
                end else begin
                    check("sb_row", out_data, exp_q[0]);
                    if (out_ready) void'(exp_q.pop_front());
                end
            end else begin
                check("idle_data", out_data, '0);
            end
        end
    end

    initial begin
        logic [W-1:0] r;
        bit en, v, rdy, clr;

        rst_n = 1'b0; clear = 1'b0; in_en = 1'b0; in_valid = 1'b0; in_data = '0;
        out_ready = 1'b0;
        clear1 = 1'b0; in_en1 = 1'b0; in_valid1 = 1'b0; in_data1 = '0; out_ready1 = 1'b0;
        model_reset();
        #2;
        check("rst_valid", W'(out_valid), '0);
        check("rst_data",  out_data,      '0);
        check("rst_full",  W'(full),      '0);
        check("rst_count", W'(count),     '0);
        check("rst_ovf",   W'(overflow),  '0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Single row, out_valid four cycles after lane 0.
        r = {16'h13, 16'h12, 16'h11, 16'h10};
        cyc(1'b1, 1'b1, r, 1'b0, 1'b0);
        idle(2, 1'b0);
        check("t1_early", W'(out_valid), '0);
        idle(1, 1'b0);
        check("t1_valid", W'(out_valid), W'(1));
        check("t1_data",  out_data,      64'h0013_0012_0011_0010);
        check("t1_count", W'(count),     W'(1));
        idle(1, 1'b1);
        check("t1_popcnt",  W'(count), '0);
        check("t1_popdata", out_data,  '0);

        // Overflow: fifth row dropped, first four drain in order.
        for (int n = 1; n <= 5; n++) cyc(1'b1, 1'b1, rep(BITS'(n)), 1'b0, 1'b0);
        idle(3, 1'b0);
        check("t2_full",  W'(full),     W'(1));
        check("t2_count", W'(count),    W'(4));
        check("t2_ovf",   W'(overflow), W'(1));
        for (int n = 1; n <= 4; n++) begin
            check("t2_order", out_data, rep(BITS'(n)));
            idle(1, 1'b1);
        end
        check("t2_empty",  W'(count),    '0);
        check("t2_sticky", W'(overflow), W'(1));

        // clear with two rows held and one in flight.
        cyc(1'b1, 1'b1, rep(16'hC1), 1'b0, 1'b0);
        cyc(1'b1, 1'b1, rep(16'hC2), 1'b0, 1'b0);
        idle(3, 1'b0);
        check("t6_pre", W'(count), W'(2));
        cyc(1'b1, 1'b1, rep(16'hC3), 1'b0, 1'b0);
        cyc(1'b1, 1'b0, '0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, '0, 1'b1, 1'b1);
        check("t6_count", W'(count),    '0);
        check("t6_ovf",   W'(overflow), '0);
        idle(6, 1'b0);
        check("t6_noghost", W'(out_valid), '0);

        // Push and pop on the same edge while full.
        for (int n = 1; n <= 4; n++) cyc(1'b1, 1'b1, rep(BITS'(16'hA0 + n)), 1'b0, 1'b0);
        idle(3, 1'b0);
        cyc(1'b1, 1'b1, rep(16'hA5), 1'b0, 1'b0);
        idle(2, 1'b0);
        idle(1, 1'b1);
        check("t3_count", W'(count),    W'(4));
        check("t3_ovf",   W'(overflow), '0);
        check("t3_head",  out_data,     rep(16'hA2));
        cyc(1'b1, 1'b0, '0, 1'b0, 1'b1);

        // Three-cycle stall in the middle of the skew.
        r = 64'h4444_3333_2222_1111;
        cyc(1'b1, 1'b1, r, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, '0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, '0, 1'b0, 1'b0);
        check("t4_early", W'(out_valid), '0);
        cyc(1'b1, 1'b0, '0, 1'b0, 1'b0);
        check("t4_valid", W'(out_valid), W'(1));
        check("t4_data",  out_data,      r);
        cyc(1'b1, 1'b0, '0, 1'b0, 1'b1);

        // Async reset between edges with two rows held and one partially in.
        cyc(1'b1, 1'b1, rep(16'hD1), 1'b0, 1'b0);
        cyc(1'b1, 1'b1, rep(16'hD2), 1'b0, 1'b0);
        idle(3, 1'b0);
        cyc(1'b1, 1'b1, rep(16'hD3), 1'b0, 1'b0);
        cyc(1'b1, 1'b0, '0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("t5_valid", W'(out_valid), '0);
        check("t5_count", W'(count),     '0);
        check("t5_data",  out_data,      '0);
        check("t5_full",  W'(full),      '0);
        cyc(1'b1, 1'b0, '0, 1'b0, 1'b0);
        rst_n = 1'b1;
        idle(6, 1'b0);
        check("t5_nopartial", W'(count), '0);
        r = 64'h0E04_0E03_0E02_0E01;
        cyc(1'b1, 1'b1, r, 1'b0, 1'b0);
        idle(3, 1'b0);
        check("t5_valid2", W'(out_valid), W'(1));
        check("t5_data2",  out_data,      r);
        idle(1, 1'b1);

        // DIM=1 build: no skew, row visible the cycle after it is presented.
        in_en = 1'b0; out_ready = 1'b0; clear = 1'b0;
        in_en1 = 1'b1; in_valid1 = 1'b1; in_data1 = 16'hBEEF;
        #1;
        check("d1_early", W'(out_valid1), '0);
        @(posedge clk); #1;
        in_valid1 = 1'b0; in_data1 = '0;
        check("d1_valid", W'(out_valid1), W'(1));
        check("d1_data",  W'(out_data1),  W'(16'hBEEF));
        check("d1_count", W'(count1),     W'(1));
        out_ready1 = 1'b1;
        @(posedge clk); #1;
        out_ready1 = 1'b0; in_en1 = 1'b0;
        check("d1_pop",   W'(count1),    '0);
        check("d1_zero",  W'(out_data1), '0);

        // Randomized traffic: a filling phase then a draining phase.
        for (int c = 0; c < 3000; c++) begin
            en  = ($urandom_range(0, 9) < 8);
            v   = 1'($urandom_range(0, 1));
            rdy = (c < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 299) == 0);
            cyc(en, v, {$urandom, $urandom}, rdy, clr);
        end
        idle(12, 1'b1);
        check("final_drain", W'(count), '0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
